// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: AXI4-Lite write master stepping each PWM channel duty toward a target per tick
// Ports: clk, rst_n (sync active-low); start/abort control; target_duty/step/tick_div config;
//   busy/done/error status; m_aw*, m_w*, m_b* write-only AXI4-Lite master (no read channel).
// Optional: define PWM_RAMP_TIMEOUT_EN for a 256-cycle AXI watchdog that sets the sticky error.
module pwm_ramp_ctrl #(
  parameter int NUM_CHANNELS = 4,
  parameter int REG_WIDTH = 16,
  parameter int AXI_ADDR_WIDTH = 5,
  parameter int AXI_DATA_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] DUTY_BASE_ADDR = 5'h10,
  parameter int TICK_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              abort,
  input  logic [NUM_CHANNELS*REG_WIDTH-1:0] target_duty,
  input  logic [REG_WIDTH-1:0]              step,
  input  logic [TICK_WIDTH-1:0]             tick_div,
  output logic                              busy,
  output logic                              done,
  output logic                              error,
  output logic                              m_awvalid,
  input  logic                              m_awready,
  output logic [AXI_ADDR_WIDTH-1:0]         m_awaddr,
  output logic                              m_wvalid,
  input  logic                              m_wready,
  output logic [AXI_DATA_WIDTH-1:0]         m_wdata,
  input  logic                              m_bvalid,
  output logic                              m_bready
);
  localparam int IW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
  typedef enum logic [2:0] {IDLE, WAIT_TICK, SCAN, WRITE, RESP, DONE} state_t;
  state_t r_st, w_nst;
  logic [REG_WIDTH-1:0] r_tgt [NUM_CHANNELS];
  logic [REG_WIDTH-1:0] r_sh [NUM_CHANNELS];
  logic [REG_WIDTH-1:0] r_step;
  logic [TICK_WIDTH-1:0] r_div, r_cnt;
  logic [IW-1:0] r_idx;
  logic r_awv, r_wv, r_abt;
  logic [REG_WIDTH-1:0] w_sh, w_tg, w_next;
  logic [REG_WIDTH:0] w_diff;
  logic w_up, w_chg, w_last, w_all_eq, w_both, w_adv, w_to;

  assign w_sh = r_sh[r_idx];
  assign w_tg = r_tgt[r_idx];
  assign w_up = w_tg > w_sh;
  // One extra bit keeps the distance exact so the final partial step lands on target
  assign w_diff = w_up ? {1'b0, w_tg} - {1'b0, w_sh} : {1'b0, w_sh} - {1'b0, w_tg};
  assign w_next = (r_step == '0 || w_diff <= {1'b0, r_step}) ? w_tg : w_up ? w_sh + r_step : w_sh - r_step;
  assign w_chg = w_next != w_sh;
  assign w_last = r_idx == IW'(NUM_CHANNELS - 1);
  assign w_both = (!r_awv || m_awready) && (!r_wv || m_wready);
  assign w_adv = !w_last && ((r_st == SCAN && !w_chg) || (r_st == RESP && m_bvalid));

  // Current channel counts as already holding w_next, so the check also serves the post-response exit
  always_comb begin
    w_all_eq = 1'b1;
    for (int i = 0; i < NUM_CHANNELS; i++)
      if (((IW'(i) == r_idx) ? w_next : r_sh[i]) != r_tgt[i]) w_all_eq = 1'b0;
  end

  always_comb begin
    w_nst = r_st;
    case (r_st)
      IDLE:      w_nst = start ? WAIT_TICK : IDLE;
      WAIT_TICK: w_nst = abort ? IDLE : (r_cnt == r_div) ? SCAN : WAIT_TICK;
      SCAN:      w_nst = w_chg ? WRITE : !w_last ? SCAN : w_all_eq ? DONE : WAIT_TICK;
      WRITE:     w_nst = w_both ? RESP : WRITE;
      RESP:      w_nst = !m_bvalid ? RESP : (abort || r_abt) ? IDLE : !w_last ? SCAN : w_all_eq ? DONE : WAIT_TICK;
      default:   w_nst = IDLE;
    endcase
    if (w_to) w_nst = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_st <= IDLE;
    else r_st <= w_nst;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_sh[i] <= '0;
        r_tgt[i] <= '0;
      end
      r_step <= '0;
      r_div <= '0;
      r_cnt <= '0;
      r_idx <= '0;
      r_awv <= 1'b0;
      r_wv <= 1'b0;
      r_abt <= 1'b0;
    end else begin
      if (r_st == IDLE && start) begin
        for (int i = 0; i < NUM_CHANNELS; i++) r_tgt[i] <= target_duty[i*REG_WIDTH +: REG_WIDTH];
        r_step <= step;
        r_div <= tick_div;
      end
      r_cnt <= (r_st == WAIT_TICK) ? r_cnt + 1'b1 : '0;
      r_idx <= (r_st == WAIT_TICK) ? '0 : w_adv ? r_idx + 1'b1 : r_idx;
      r_awv <= !w_to && ((r_st == SCAN && w_chg) || (r_awv && !m_awready));
      r_wv <= !w_to && ((r_st == SCAN && w_chg) || (r_wv && !m_wready));
      // Abort is remembered across the write so it takes effect once the response arrives
      r_abt <= r_st != SCAN && (r_abt || abort);
      if (r_st == RESP && m_bvalid && !w_to) r_sh[r_idx] <= w_next;
    end
  end

`ifdef PWM_RAMP_TIMEOUT_EN
  logic [7:0] r_wd;
  logic r_err, w_hs, w_axi;
  assign w_axi = r_st == WRITE || r_st == RESP;
  assign w_hs = (r_awv && m_awready) || (r_wv && m_wready) || (r_st == RESP && m_bvalid);
  assign w_to = w_axi && r_wd == 8'hFF && !w_hs;
  assign error = r_err;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wd <= '0;
      r_err <= 1'b0;
    end else begin
      r_wd <= (w_hs || !w_axi) ? '0 : r_wd + 1'b1;
      r_err <= w_to || (r_err && !(r_st == IDLE && start));
    end
  end
`else
  assign w_to = 1'b0;
  assign error = 1'b0;
`endif

  assign busy = r_st != IDLE && r_st != DONE;
  assign done = r_st == DONE;
  assign m_awvalid = r_awv;
  assign m_wvalid = r_wv;
  assign m_bready = r_st == RESP;
  assign m_awaddr = r_awv ? DUTY_BASE_ADDR + AXI_ADDR_WIDTH'({r_idx, 2'b00}) : '0;
  assign m_wdata = r_wv ? AXI_DATA_WIDTH'(w_next) : '0;
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: directed checks of the duty ramp sequencer against hand-computed write lists
module tb_pwm_ramp_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [63:0] target_duty = '0;
  logic [15:0] step = '0, tick_div = '0;
  logic busy, done, error, m_awvalid, m_wvalid, m_bready;
  logic m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0;
  logic [4:0] m_awaddr;
  logic [31:0] m_wdata;
  int n_tot = 0, n_bad = 0, cyc = 0, aw_dly = 0, aw_cnt = 0;
  int n_done = 0, n_awv = 0, n_wv = 0, n_uns = 0;
  int ba, bd, bb, bdn, baw, bwv, lat;
  bit b_en = 1'b1, pv = 1'b0;
  logic [4:0] pa = '0;
  logic [4:0] aq[$];
  logic [31:0] dq[$];
  int at[$], wt[$], bt[$];

  pwm_ramp_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .target_duty(target_duty),
    .step(step), .tick_div(tick_div), .busy(busy), .done(done), .error(error),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
    .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  always #5 clk = ~clk;

  // Slave model and logger; values seen here are what the following rising edge samples
  always @(negedge clk) begin
    cyc++;
    if (m_awvalid) begin
      m_awready = aw_cnt >= aw_dly;
      aw_cnt++;
    end else begin
      m_awready = 1'b0;
      aw_cnt = 0;
    end
    m_wready = 1'b1;
    m_bvalid = m_bready && b_en;
    if (m_awvalid && m_awready) begin aq.push_back(m_awaddr); at.push_back(cyc); end
    if (m_wvalid && m_wready) begin dq.push_back(m_wdata); wt.push_back(cyc); end
    if (m_bvalid && m_bready) bt.push_back(cyc);
    if (done) n_done++;
    if (m_awvalid) n_awv++;
    if (m_wvalid) n_wv++;
    if (m_awvalid && pv && m_awaddr != pa) n_uns++;
    pv = m_awvalid && !m_awready;
    pa = m_awaddr;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pk(input logic [15:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic mark();
    ba = aq.size(); bd = dq.size(); bb = bt.size();
    bdn = n_done; baw = n_awv; bwv = n_wv;
  endtask

  task automatic kick(input logic [63:0] t, input logic [15:0] s, input logic [15:0] d);
    mark();
    @(negedge clk);
    target_duty = t; step = s; tick_div = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
    chk("idle_bound", 32'(busy), 0);
    @(negedge clk);
  endtask

  task automatic ck_n(input string tag, input int n);
    chk({tag, "_aw_count"}, 32'(aq.size() - ba), 32'(n));
    chk({tag, "_w_count"}, 32'(dq.size() - bd), 32'(n));
  endtask

  task automatic ck_wr(input string tag, input int i, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_addr"}, (ba + i < aq.size()) ? 32'(aq[ba + i]) : 32'hDEADBEEF, 32'(a));
    chk({tag, "_data"}, (bd + i < dq.size()) ? dq[bd + i] : 32'hDEADBEEF, d);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_awvalid", 32'(m_awvalid), 0);
    chk("rst_wvalid", 32'(m_wvalid), 0);
    chk("rst_bready", 32'(m_bready), 0);
    chk("rst_awaddr", 32'(m_awaddr), 0);
    chk("rst_wdata", m_wdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    kick(pk(10, 0, 0, 0), 4, 2);
    chk("busy_after_start", 32'(busy), 1);
    lat = 1;
    while (!m_awvalid && lat < 100) begin @(negedge clk); lat++; end
    chk("first_write_cycle", 32'(lat), 5);
    wait_idle();
    ck_n("up", 3);
    ck_wr("up0", 0, 5'h10, 4);
    ck_wr("up1", 1, 5'h10, 8);
    ck_wr("up2", 2, 5'h10, 10);
    chk("up_done", 32'(n_done - bdn), 1);
    chk("up_tick_gap", (bd + 1 < wt.size()) ? 32'(wt[bd + 1] - wt[bd] >= 3) : 0, 1);

    kick(pk(10, 3, 0, 0), 0, 0);
    wait_idle();
    ck_n("set_ch1", 1);
    ck_wr("set_ch1", 0, 5'h14, 3);

    kick(pk(0, 0, 0, 0), 5, 1);
    wait_idle();
    ck_n("down", 3);
    ck_wr("down0", 0, 5'h10, 5);
    ck_wr("down1", 1, 5'h14, 0);
    ck_wr("down2", 2, 5'h10, 0);
    chk("down_done", 32'(n_done - bdn), 1);

    kick(pk(0, 8, 0, 0), 5, 1);
    wait_idle();
    ck_n("up_ch1", 2);
    ck_wr("up_ch1_0", 0, 5'h14, 5);
    ck_wr("up_ch1_1", 1, 5'h14, 8);

    aw_dly = 3;
    kick(pk(0, 8, 7, 0), 0, 0);
    wait_idle();
    aw_dly = 0;
    ck_n("bp", 1);
    ck_wr("bp", 0, 5'h18, 7);
    chk("bp_wvalid_cycles", 32'(n_wv - bwv), 1);
    chk("bp_awvalid_cycles", 32'(n_awv - baw), 4);
    chk("bp_aw_after_w", (ba < at.size() && bd < wt.size()) ? 32'(at[ba] - wt[bd]) : 32'hDEAD, 3);
    chk("bp_b_after_aw", (ba < at.size() && bb < bt.size()) ? 32'(bt[bb] - at[ba]) : 32'hDEAD, 1);
    chk("bp_awaddr_stable", 32'(n_uns), 0);

    aw_dly = 2;
    kick(pk(0, 8, 7, 100), 10, 1);
    lat = 0;
    while (!m_awvalid && lat < 100) begin @(negedge clk); lat++; end
    chk("abort_saw_write", 32'(m_awvalid), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle();
    aw_dly = 0;
    ck_n("abort", 1);
    ck_wr("abort", 0, 5'h1C, 10);
    chk("abort_b_count", 32'(bt.size() - bb), 1);
    chk("abort_no_done", 32'(n_done - bdn), 0);

    kick(pk(0, 8, 7, 40), 10, 3);
    repeat (2) @(negedge clk);
    target_duty = pk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF); step = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    ck_n("ign_start", 3);
    ck_wr("ign0", 0, 5'h1C, 20);
    ck_wr("ign1", 1, 5'h1C, 30);
    ck_wr("ign2", 2, 5'h1C, 40);
    chk("ign_done", 32'(n_done - bdn), 1);

    kick(pk(16'hFFFF, 8, 7, 40), 0, 0);
    wait_idle();
    ck_n("jump", 1);
    ck_wr("jump", 0, 5'h10, 32'h0000FFFF);

    kick(pk(16'hFFF0, 8, 7, 40), 0, 0);
    wait_idle();
    ck_wr("jump_down", 0, 5'h10, 32'h0000FFF0);
    kick(pk(16'hFFFF, 8, 7, 40), 16'hFFFF, 0);
    wait_idle();
    ck_n("big_step", 1);
    ck_wr("big_step", 0, 5'h10, 32'h0000FFFF);

    kick(pk(16'hFFFF, 8, 7, 40), 3, 2);
    wait_idle();
    ck_n("noop", 0);
    chk("noop_done", 32'(n_done - bdn), 1);

    aw_dly = 50;
    kick(pk(0, 8, 7, 40), 1, 0);
    lat = 0;
    while (!m_awvalid && lat < 100) begin @(negedge clk); lat++; end
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_awvalid", 32'(m_awvalid), 0);
    chk("midrst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    aw_dly = 0;
    @(negedge clk);
    kick(pk(0, 0, 0, 5), 0, 0);
    wait_idle();
    ck_n("after_rst", 1);
    ck_wr("after_rst", 0, 5'h1C, 5);

`ifdef PWM_RAMP_TIMEOUT_EN
    b_en = 1'b0;
    kick(pk(1, 0, 0, 5), 0, 0);
    lat = 0;
    while (busy && lat < 600) begin @(negedge clk); lat++; end
    chk("to_idle", 32'(busy), 0);
    chk("to_error", 32'(error), 1);
    chk("to_bready", 32'(m_bready), 0);
    chk("to_no_done", 32'(n_done - bdn), 0);
    b_en = 1'b1;
    kick(pk(1, 0, 0, 5), 0, 0);
    chk("to_error_cleared", 32'(error), 0);
    wait_idle();
`else
    chk("error_tied_low", 32'(error), 0);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
